fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined core. It sits directly upstream of the synchronous instruction memory and consumes its read data.
- Owns the program counter and drives the word address to the instruction memory.
- Pairs the instruction that returns one cycle later with its PC and presents the pair to the IF/ID register with a valid flag.
- Handles downstream stall, redirect (branch/jump/trap) and the post-reset start-up bubble.

---
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's external signals: downstream control
// (stall/redirect), the synchronous instruction-memory port and the
// instruction presented to the IF/ID register.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 10
);
  // Control from later pipeline stages
  logic                  stall;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;

  // Synchronous instruction memory port
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;

  // Instruction handed to IF/ID
  logic [31:0]           if_pc;
  logic [31:0]           if_instr;
  logic                  if_valid;
  logic                  if_misaligned;

  // The fetch stage itself
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, if_pc, if_instr, if_valid, if_misaligned
  );

  // Surroundings: pipeline control, instruction memory and IF/ID register
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, if_pc, if_instr, if_valid, if_misaligned
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC and presents the next word address to
// a synchronous instruction memory. Because the PC register is loaded with the
// same value that addresses the memory, the data returning one cycle later
// always belongs to pc_q, which hides the memory latency. A single BOOT bubble
// follows reset, so the first read can complete before anything is marked valid.
module fetch_stage #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  run_state_t  run_q;
  logic        mis_q;
  logic        valid;

  // Pick the address fetched next: reset, redirect, hold (boot/stall) or advance
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (bus.redirect_valid) begin
      next_pc = {bus.redirect_pc[31:2], 2'b00};
    end else if (run_q == BOOT || bus.stall) begin
      next_pc = pc_q;
    end
  end

  // Track the PC, leave BOOT once, and remember whether a redirect target was misaligned
  always_ff @(posedge clk) begin
    pc_q <= next_pc;
    if (rst) begin
      run_q <= BOOT;
      mis_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      run_q <= RUN;
      mis_q <= (bus.redirect_pc[1:0] != 2'b00);
    end else if (run_q == BOOT) begin
      run_q <= RUN;
    end else if (!bus.stall) begin
      mis_q <= 1'b0;
    end
  end

  assign valid             = (run_q == RUN) & ~bus.redirect_valid & ~rst;

  assign bus.imem_addr     = next_pc[ADDR_WIDTH+1:2];
  assign bus.if_pc         = pc_q;
  assign bus.if_instr      = bus.imem_data;
  assign bus.if_valid      = valid;
  assign bus.if_misaligned = mis_q & valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a synchronous instruction memory filled with random
// words, a reference model of the instruction stream, a directed sequence
// covering boot, stall, redirect, misalignment, wrap and mid-run reset, then
// a randomized phase.
module tb_fetch_stage;

  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(AW)) bus();

  fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  // Synchronous instruction memory: data is the word addressed last cycle
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  int checks = 0;
  int errors = 0;

  // Reference model: the PC whose instruction is on the output, whether the
  // post-reset bubble is showing, and whether that PC came from a misaligned redirect
  logic [31:0] m_pc;
  bit          m_boot = 1'b1;
  bit          m_mis  = 1'b0;

  logic [31:0] obs_pc, obs_instr;
  logic        obs_valid, obs_mis;
  logic [AW-1:0] obs_addr;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Which PC the model says is fetched next, given this cycle's inputs
  function automatic logic [31:0] fetchTarget(input bit r, input bit s, input bit v,
                                              input logic [31:0] p);
    if (r) return RPC;
    if (v) return p & 32'hFFFF_FFFC;
    if (m_boot || s) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic checkOutput(input bit r, input bit s, input bit v, input logic [31:0] p);
    logic [31:0] tgt;
    logic [31:0] word_idx;
    bit          exp_valid;
    obs_pc    = bus.if_pc;
    obs_instr = bus.if_instr;
    obs_valid = bus.if_valid;
    obs_mis   = bus.if_misaligned;
    obs_addr  = bus.imem_addr;
    tgt       = fetchTarget(r, s, v, p);
    exp_valid = !m_boot && !v && !r;
    checkValue("imem_addr", {{(32-AW){1'b0}}, obs_addr}, {{(32-AW){1'b0}}, tgt[AW+1:2]});
    checkValue("if_valid", {31'b0, obs_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      word_idx = {{(32-AW){1'b0}}, m_pc[AW+1:2]};
      checkValue("if_pc", obs_pc, m_pc);
      checkValue("if_instr", obs_instr, mem[word_idx]);
      checkValue("if_misaligned", {31'b0, obs_mis}, {31'b0, m_mis});
    end else begin
      checkValue("if_misaligned_squashed", {31'b0, obs_mis}, 32'd0);
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance the model at the edge
  task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [31:0] p);
    logic [31:0] nxt;
    rst                = r;
    bus.stall          = s;
    bus.redirect_valid = v;
    bus.redirect_pc    = p;
    @(negedge clk);
    checkOutput(r, s, v, p);
    @(posedge clk);
    nxt = fetchTarget(r, s, v, p);
    if (r) begin
      m_boot = 1'b1;
      m_mis  = 1'b0;
    end else if (v) begin
      m_boot = 1'b0;
      m_mis  = (p[1:0] != 2'b00);
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!s) begin
      m_mis = 1'b0;
    end
    m_pc = nxt;
    #1;
  endtask

  initial begin
    logic [31:0] held_instr;
    bit          r, s, v;
    logic [31:0] p;

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    // Reset held three cycles, then boot bubble, then sequential fetch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 32'h0);
      checkValue("rst_addr", {22'b0, obs_addr}, 32'h40);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("boot_valid", {31'b0, obs_valid}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("first_pc", obs_pc, 32'h100);
    checkValue("first_valid", {31'b0, obs_valid}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("seq_pc1", obs_pc, 32'h104);

    // Stall three cycles on 0x108
    applyStimulus(0, 1, 0, 32'h0);
    checkValue("stall_pc0", obs_pc, 32'h108);
    held_instr = obs_instr;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checkValue("stall_pc", obs_pc, 32'h108);
      checkValue("stall_instr", obs_instr, held_instr);
      checkValue("stall_valid", {31'b0, obs_valid}, 32'd1);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("release_pc", obs_pc, 32'h108);

    // Redirect to 0x200 while 0x10C is showing
    applyStimulus(0, 0, 1, 32'h200);
    checkValue("redir_pc_squashed", obs_pc, 32'h10C);
    checkValue("redir_valid", {31'b0, obs_valid}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("redir_target", obs_pc, 32'h200);
    checkValue("redir_instr", obs_instr, mem[32'h80]);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("redir_next", obs_pc, 32'h204);

    // Redirect + stall together, to a misaligned target
    applyStimulus(0, 1, 1, 32'h302);
    applyStimulus(0, 1, 0, 32'h0);
    checkValue("mis_pc", obs_pc, 32'h300);
    checkValue("mis_flag", {31'b0, obs_mis}, 32'd1);
    applyStimulus(0, 1, 0, 32'h0);
    checkValue("mis_held", {31'b0, obs_mis}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("mis_clear_pc", obs_pc, 32'h304);
    checkValue("mis_clear", {31'b0, obs_mis}, 32'd0);

    // Wrap/alias across the memory depth
    applyStimulus(0, 0, 1, 32'hFFC);
    checkValue("wrap_addr0", {22'b0, obs_addr}, 32'h3FF);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("wrap_pc0", obs_pc, 32'hFFC);
    checkValue("wrap_addr1", {22'b0, obs_addr}, 32'h000);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("wrap_pc1", obs_pc, 32'h1000);
    checkValue("wrap_instr", obs_instr, mem[0]);

    // Reset mid-run while stalled on 0x204
    applyStimulus(0, 0, 1, 32'h204);
    applyStimulus(0, 1, 0, 32'h0);
    checkValue("mid_pc", obs_pc, 32'h204);
    applyStimulus(1, 1, 0, 32'h0);
    checkValue("mid_rst_valid", {31'b0, obs_valid}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("mid_boot_valid", {31'b0, obs_valid}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0);
    checkValue("mid_restart_pc", obs_pc, RPC);
    checkValue("mid_restart_valid", {31'b0, obs_valid}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_0FFF);
      applyStimulus(r, s, v, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
